fx2_bus_arbiter: RTL and testbench

FX2_BUS_ARBITER -- requirements
Module: fx2_bus_arbiter

---
 rtl/fx2_bus_arbiter_if.sv | 47 ++++
 rtl/fx2_bus_arbiter.sv | 110 +++++++++++
 tb/tb_fx2_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fx2_bus_arbiter_if.sv
// fx2_bus_arbiter_if: bundles the FX2 slave-FIFO pins and the user-side rx/tx streams.
// Ports (master = arbiter side):
//   fx2_flaga/b      EP2/EP4 empty flags (active low), fx2_flagc/d EP6/EP8 full flags (active low)
//   fx2_slrd/slwr/sloe/pktend  FX2 strobes (active low), fx2_fifoaddr endpoint select
//   fx2_fd_in/fx2_fd_out/fx2_fd_oe  FX2 data bus split into in/out/enable
//   rx_data/rx_valid/rx_ep/rx_ready  OUT-endpoint data stream towards the user logic
//   tx_data0/tx_data1/tx_valid/tx_last/tx_ready  IN-endpoint streams (bit0 EP6, bit1 EP8)
//   busy/grant       arbiter status
interface fx2_bus_arbiter_if;
    logic        fx2_flaga;
    logic        fx2_flagb;
    logic        fx2_flagc;
    logic        fx2_flagd;
    logic        fx2_slrd;
    logic        fx2_slwr;
    logic        fx2_sloe;
    logic        fx2_pktend;
    logic [1:0]  fx2_fifoaddr;
    logic [15:0] fx2_fd_in;
    logic [15:0] fx2_fd_out;
    logic        fx2_fd_oe;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ep;
    logic        rx_ready;
    logic [15:0] tx_data0;
    logic [15:0] tx_data1;
    logic [1:0]  tx_valid;
    logic [1:0]  tx_last;
    logic [1:0]  tx_ready;
    logic        busy;
    logic [1:0]  grant;

    modport master (
        input  fx2_flaga, fx2_flagb, fx2_flagc, fx2_flagd, fx2_fd_in,
        input  rx_ready, tx_data0, tx_data1, tx_valid, tx_last,
        output fx2_slrd, fx2_slwr, fx2_sloe, fx2_pktend, fx2_fifoaddr,
        output fx2_fd_out, fx2_fd_oe, rx_data, rx_valid, rx_ep, tx_ready, busy, grant
    );

    modport slave (
        output fx2_flaga, fx2_flagb, fx2_flagc, fx2_flagd, fx2_fd_in,
        output rx_ready, tx_data0, tx_data1, tx_valid, tx_last,
        input  fx2_slrd, fx2_slwr, fx2_sloe, fx2_pktend, fx2_fifoaddr,
        input  fx2_fd_out, fx2_fd_oe, rx_data, rx_valid, rx_ep, tx_ready, busy, grant
    );
endinterface

// File: rtl/fx2_bus_arbiter.sv
// fx2_bus_arbiter: round-robin arbiter moving bursts between four FX2 endpoints and user streams.
// Ports:
//   clk      FX2 interface clock, all logic on rising edge
//   reset_n  asynchronous active-low reset
//   bus      fx2_bus_arbiter_if.master: FX2 pins, rx stream (EP2/EP4), tx streams (EP6/EP8), busy/grant
// Parameter BURST_MAX: maximum words moved per grant (1..255).
module fx2_bus_arbiter #(
    parameter int BURST_MAX = 16
) (
    input logic               clk,
    input logic               reset_n,
    fx2_bus_arbiter_if.master bus
);
    typedef enum logic [2:0] {IDLE, ADDR, RD_OE, RD, WR, PKTEND, TURN} state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d, pick;
    logic [7:0]  count_q, count_d;
    logic [15:0] rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d, rx_ep_q, rx_ep_d;
    logic [3:0]  elig;
    logic        found, sel_flag, rd_ok, wr_ok, tx_i, cnt_hit;

    assign elig = {bus.fx2_flagd & bus.tx_valid[1], bus.fx2_flagc & bus.tx_valid[0],
                   bus.fx2_flagb & bus.rx_ready,    bus.fx2_flaga & bus.rx_ready};
    assign tx_i = grant_q[0];
    assign sel_flag = grant_q[1] ? (grant_q[0] ? bus.fx2_flagd : bus.fx2_flagc)
                                 : (grant_q[0] ? bus.fx2_flagb : bus.fx2_flaga);
    assign rd_ok = (state_q == RD) && sel_flag && bus.rx_ready;
    assign wr_ok = (state_q == WR) && sel_flag && bus.tx_valid[tx_i];
    // Compare the post-increment count so the limiting strobe itself ends the burst.
    assign cnt_hit = (count_q + 8'd1) == 8'(BURST_MAX);

    // Search starts one past the last grant; the 2-bit sum wraps EP8 back to EP2,
    // and the 4th step revisits the last grant when it is the only one eligible.
    always_comb begin
        pick  = grant_q;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!found && elig[grant_q + 2'(i)]) begin
                pick  = grant_q + 2'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        count_d    = count_q;
        rx_valid_d = rd_ok;
        rx_data_d  = rd_ok ? bus.fx2_fd_in : rx_data_q;
        rx_ep_d    = rd_ok ? grant_q[0] : rx_ep_q;
        case (state_q)
            IDLE: if (found) begin
                state_d = ADDR;
                grant_d = pick;
                count_d = 8'd0;
            end
            ADDR:   state_d = grant_q[1] ? WR : RD_OE;
            RD_OE:  state_d = RD;
            RD: begin
                count_d = rd_ok ? count_q + 8'd1 : count_q;
                state_d = (!rd_ok || cnt_hit) ? TURN : RD;
            end
            WR: begin
                count_d = wr_ok ? count_q + 8'd1 : count_q;
                // tx_last wins over the count limit so the packet is always committed.
                state_d = (wr_ok && bus.tx_last[tx_i]) ? PKTEND : (!wr_ok || cnt_hit) ? TURN : WR;
            end
            PKTEND: state_d = TURN;
            TURN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            grant_q    <= 2'b11;
            count_q    <= 8'd0;
            rx_data_q  <= 16'd0;
            rx_valid_q <= 1'b0;
            rx_ep_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            count_q    <= count_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ep_q    <= rx_ep_d;
        end
    end

    // Output enable is tied to the write strobe, which only exists in WR, so it can
    // never overlap the sloe-low window of RD_OE/RD.
    assign bus.fx2_slrd     = !rd_ok;
    assign bus.fx2_slwr     = !wr_ok;
    assign bus.fx2_sloe     = !(state_q == RD_OE || state_q == RD);
    assign bus.fx2_pktend   = state_q != PKTEND;
    assign bus.fx2_fd_oe    = wr_ok;
    assign bus.fx2_fd_out   = wr_ok ? (tx_i ? bus.tx_data1 : bus.tx_data0) : 16'd0;
    assign bus.fx2_fifoaddr = (state_q == IDLE) ? 2'b00 : grant_q;
    assign bus.tx_ready     = wr_ok ? (tx_i ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rx_data      = rx_data_q;
    assign bus.rx_valid     = rx_valid_q;
    assign bus.rx_ep        = rx_ep_q;
    assign bus.busy         = state_q != IDLE;
    assign bus.grant        = grant_q;
endmodule

// File: tb/tb_fx2_bus_arbiter.sv
// tb_fx2_bus_arbiter: directed self-checking bench for fx2_bus_arbiter.
module tb_fx2_bus_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    int   nvec = 0;
    int   nerr = 0;

    fx2_bus_arbiter_if b();
    fx2_bus_arbiter_if r();

    fx2_bus_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(b.master));
    fx2_bus_arbiter #(.BURST_MAX(2)) rr (.clk(clk), .reset_n(reset_n), .bus(r.master));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, 32'(b.busy), 0);
        chk({tag, "_grant"}, 32'(b.grant), 3);
        chk({tag, "_strobes"}, 32'({b.fx2_slrd, b.fx2_slwr, b.fx2_sloe, b.fx2_pktend}), 'hf);
        chk({tag, "_fd_oe"}, 32'(b.fx2_fd_oe), 0);
        chk({tag, "_fd_out"}, 32'(b.fx2_fd_out), 0);
        chk({tag, "_fifoaddr"}, 32'(b.fx2_fifoaddr), 0);
        chk({tag, "_rx_valid"}, 32'(b.rx_valid), 0);
        chk({tag, "_rx_data"}, 32'(b.rx_data), 0);
        chk({tag, "_tx_ready"}, 32'(b.tx_ready), 0);
    endtask

    task automatic zero_b();
        b.fx2_flaga = 0; b.fx2_flagb = 0; b.fx2_flagc = 0; b.fx2_flagd = 0;
        b.fx2_fd_in = 0; b.rx_ready = 0; b.tx_data0 = 0; b.tx_data1 = 0;
        b.tx_valid = 0; b.tx_last = 0;
    endtask

    task automatic zero_r();
        r.fx2_flaga = 0; r.fx2_flagb = 0; r.fx2_flagc = 0; r.fx2_flagd = 0;
        r.fx2_fd_in = 0; r.rx_ready = 0; r.tx_data0 = 0; r.tx_data1 = 0;
        r.tx_valid = 0; r.tx_last = 0;
    endtask

    initial begin
        int   bursts;
        int   cnt;
        logic pb;
        reset_n = 1'b0;
        zero_b();
        zero_r();
        repeat (2) @(negedge clk);
        #1;
        check_reset("rst");
        reset_n = 1'b1;

        // Round robin with every endpoint eligible, bursts of 2
        @(negedge clk);
        r.fx2_flaga = 1; r.fx2_flagb = 1; r.fx2_flagc = 1; r.fx2_flagd = 1;
        r.rx_ready = 1; r.tx_valid = 2'b11;
        bursts = 0; cnt = 0; pb = 1'b0;
        for (int c = 0; c < 60 && bursts < 6; c++) begin
            @(negedge clk);
            #1;
            if (!r.fx2_slrd || !r.fx2_slwr) cnt++;
            if (r.busy && !pb) begin
                if (bursts > 0) chk("rr_len", cnt, 2);
                if (bursts < 5) chk("rr_grant", 32'(r.grant), bursts % 4);
                bursts++;
                cnt = 0;
            end
            pb = r.busy;
        end
        chk("rr_done", bursts, 6);
        zero_r();

        // EP2 read burst of three words ended by the empty flag
        @(negedge clk);
        b.fx2_flaga = 1; b.rx_ready = 1; b.fx2_fd_in = 16'h1111;
        #1;
        chk("t1_idle_busy", 32'(b.busy), 0);
        @(negedge clk); #1;
        chk("t1_addr_busy", 32'(b.busy), 1);
        chk("t1_addr_fifoaddr", 32'(b.fx2_fifoaddr), 0);
        chk("t1_addr_strobes", 32'({b.fx2_slrd, b.fx2_slwr, b.fx2_sloe, b.fx2_pktend}), 'hf);
        @(negedge clk); #1;
        chk("t1_rdoe_sloe", 32'(b.fx2_sloe), 0);
        chk("t1_rdoe_slrd", 32'(b.fx2_slrd), 1);
        chk("t1_rdoe_fd_oe", 32'(b.fx2_fd_oe), 0);
        @(negedge clk); #1;
        chk("t1_rd1_slrd", 32'(b.fx2_slrd), 0);
        chk("t1_rd1_sloe", 32'(b.fx2_sloe), 0);
        chk("t1_rd1_rx_valid", 32'(b.rx_valid), 0);
        @(negedge clk);
        b.fx2_fd_in = 16'h2222;
        #1;
        chk("t1_rd2_slrd", 32'(b.fx2_slrd), 0);
        chk("t1_rx1_valid", 32'(b.rx_valid), 1);
        chk("t1_rx1_data", 32'(b.rx_data), 'h1111);
        chk("t1_rx1_ep", 32'(b.rx_ep), 0);
        @(negedge clk);
        b.fx2_fd_in = 16'h3333;
        #1;
        chk("t1_rd3_slrd", 32'(b.fx2_slrd), 0);
        chk("t1_rx2_data", 32'(b.rx_data), 'h2222);
        @(negedge clk);
        b.fx2_flaga = 0;
        #1;
        chk("t1_empty_slrd", 32'(b.fx2_slrd), 1);
        chk("t1_rx3_valid", 32'(b.rx_valid), 1);
        chk("t1_rx3_data", 32'(b.rx_data), 'h3333);
        @(negedge clk); #1;
        chk("t1_turn_busy", 32'(b.busy), 1);
        chk("t1_turn_sloe", 32'(b.fx2_sloe), 1);
        chk("t1_turn_rx_valid", 32'(b.rx_valid), 0);
        chk("t1_turn_fd_oe", 32'(b.fx2_fd_oe), 0);
        @(negedge clk);
        b.rx_ready = 0;
        #1;
        chk("t1_done_busy", 32'(b.busy), 0);
        chk("t1_done_grant", 32'(b.grant), 0);

        // EP8 write of four words closed by tx_last and a pktend
        @(negedge clk);
        b.fx2_flagd = 1; b.tx_valid = 2'b10; b.tx_data1 = 16'hA001;
        #1;
        chk("t2_idle_busy", 32'(b.busy), 0);
        @(negedge clk); #1;
        chk("t2_addr_grant", 32'(b.grant), 3);
        chk("t2_addr_fifoaddr", 32'(b.fx2_fifoaddr), 3);
        chk("t2_addr_slwr", 32'(b.fx2_slwr), 1);
        chk("t2_addr_fd_oe", 32'(b.fx2_fd_oe), 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            b.tx_data1 = 16'hA000 + 16'(k);
            b.tx_last = (k == 4) ? 2'b10 : 2'b00;
            #1;
            chk("t2_wr_slwr", 32'(b.fx2_slwr), 0);
            chk("t2_wr_fd_oe", 32'(b.fx2_fd_oe), 1);
            chk("t2_wr_sloe", 32'(b.fx2_sloe), 1);
            chk("t2_wr_fd_out", 32'(b.fx2_fd_out), 'hA000 + k);
            chk("t2_wr_tx_ready", 32'(b.tx_ready), 2);
            chk("t2_wr_fifoaddr", 32'(b.fx2_fifoaddr), 3);
            chk("t2_wr_pktend", 32'(b.fx2_pktend), 1);
        end
        @(negedge clk);
        b.tx_valid = 0; b.tx_last = 0;
        #1;
        chk("t2_pktend", 32'(b.fx2_pktend), 0);
        chk("t2_pktend_slwr", 32'(b.fx2_slwr), 1);
        chk("t2_pktend_tx_ready", 32'(b.tx_ready), 0);
        @(negedge clk); #1;
        chk("t2_turn_pktend", 32'(b.fx2_pktend), 1);
        chk("t2_turn_fd_oe", 32'(b.fx2_fd_oe), 0);
        chk("t2_turn_busy", 32'(b.busy), 1);
        @(negedge clk);
        b.fx2_flagd = 0;
        #1;
        chk("t2_done_busy", 32'(b.busy), 0);

        // EP6 write cut short by the full flag after two words
        @(negedge clk);
        b.fx2_flagc = 1; b.tx_valid = 2'b01; b.tx_data0 = 16'hB001;
        #1;
        chk("t3_idle_busy", 32'(b.busy), 0);
        @(negedge clk); #1;
        chk("t3_addr_grant", 32'(b.grant), 2);
        chk("t3_addr_fifoaddr", 32'(b.fx2_fifoaddr), 2);
        @(negedge clk); #1;
        chk("t3_w1_slwr", 32'(b.fx2_slwr), 0);
        chk("t3_w1_fd_out", 32'(b.fx2_fd_out), 'hB001);
        chk("t3_w1_tx_ready", 32'(b.tx_ready), 1);
        @(negedge clk);
        b.tx_data0 = 16'hB002;
        #1;
        chk("t3_w2_slwr", 32'(b.fx2_slwr), 0);
        chk("t3_w2_fd_out", 32'(b.fx2_fd_out), 'hB002);
        @(negedge clk);
        b.fx2_flagc = 0;
        #1;
        chk("t3_full_slwr", 32'(b.fx2_slwr), 1);
        chk("t3_full_tx_ready", 32'(b.tx_ready), 0);
        chk("t3_full_fd_oe", 32'(b.fx2_fd_oe), 0);
        chk("t3_full_pktend", 32'(b.fx2_pktend), 1);
        @(negedge clk); #1;
        chk("t3_turn_busy", 32'(b.busy), 1);
        chk("t3_turn_pktend", 32'(b.fx2_pktend), 1);
        chk("t3_turn_slwr", 32'(b.fx2_slwr), 1);
        @(negedge clk);
        b.tx_valid = 0;
        #1;
        chk("t3_done_busy", 32'(b.busy), 0);

        // EP4 read stopped by rx_ready dropping
        @(negedge clk);
        b.fx2_flagb = 1; b.rx_ready = 1; b.fx2_fd_in = 16'hC001;
        #1;
        chk("t4_idle_busy", 32'(b.busy), 0);
        @(negedge clk); #1;
        chk("t4_addr_grant", 32'(b.grant), 1);
        chk("t4_addr_fifoaddr", 32'(b.fx2_fifoaddr), 1);
        @(negedge clk); #1;
        chk("t4_rdoe_sloe", 32'(b.fx2_sloe), 0);
        @(negedge clk); #1;
        chk("t4_rd_slrd", 32'(b.fx2_slrd), 0);
        @(negedge clk);
        b.rx_ready = 0;
        #1;
        chk("t4_drop_slrd", 32'(b.fx2_slrd), 1);
        chk("t4_rx_valid", 32'(b.rx_valid), 1);
        chk("t4_rx_data", 32'(b.rx_data), 'hC001);
        chk("t4_rx_ep", 32'(b.rx_ep), 1);
        @(negedge clk); #1;
        chk("t4_turn_busy", 32'(b.busy), 1);
        chk("t4_turn_sloe", 32'(b.fx2_sloe), 1);
        @(negedge clk);
        b.fx2_flagb = 0;
        #1;
        chk("t4_done_busy", 32'(b.busy), 0);

        // Reset pulsed during an EP6 write; EP2 must win afterwards
        @(negedge clk);
        b.fx2_flaga = 1; b.rx_ready = 1; b.fx2_flagc = 1; b.tx_valid = 2'b01; b.tx_data0 = 16'hD001;
        #1;
        chk("t5_idle_busy", 32'(b.busy), 0);
        @(negedge clk); #1;
        chk("t5_addr_grant", 32'(b.grant), 2);
        @(negedge clk); #1;
        chk("t5_w1_slwr", 32'(b.fx2_slwr), 0);
        @(negedge clk); #1;
        chk("t5_w2_slwr", 32'(b.fx2_slwr), 0);
        reset_n = 1'b0;
        #1;
        check_reset("t5_rst");
        @(negedge clk); #1;
        chk("t5_rst_pktend", 32'(b.fx2_pktend), 1);
        chk("t5_rst_slwr", 32'(b.fx2_slwr), 1);
        reset_n = 1'b1;
        @(negedge clk); #1;
        chk("t5_regrant", 32'(b.grant), 0);
        chk("t5_regrant_busy", 32'(b.busy), 1);
        zero_b();
        repeat (6) @(negedge clk);
        #1;
        chk("t5_done_busy", 32'(b.busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
